// File: rtl/mem2d_rd_scan.sv
// Rectangular-region read scanner for a 2-D memory: walks columns then rows and streams elements over valid/ready.
// Optional running XOR checksum output enabled by defining MEM2D_RD_CSUM_EN.
module mem2d_rd_scan (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] x0,
    input  logic [4:0] y0,
    input  logic [5:0] w_m1,
    input  logic [4:0] h_m1,
    output logic [5:0] mem_addr_x,
    output logic [4:0] mem_addr_y,
    output logic       mem_wr,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       busy,
    output logic       done
`ifdef MEM2D_RD_CSUM_EN
    ,
    output logic [7:0] csum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] x0_q, x0_d;
    logic [4:0] y0_q, y0_d;
    logic [5:0] w_q, w_d;
    logic [4:0] h_q, h_d;
    logic [5:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [5:0] addr_x_q, addr_x_d;
    logic [4:0] addr_y_q, addr_y_d;
    logic [7:0] m_data_q, m_data_d;
    logic       m_valid_q, m_valid_d;
    logic       m_last_q, m_last_d;
    logic       done_q, done_d;
    logic [7:0] csum_q, csum_d;

    logic xfer;
    logic capture;
    logic last_elem;

    assign xfer      = m_valid_q & m_ready;
    assign capture   = (state_q == SCAN) & (~m_valid_q | m_ready);
    assign last_elem = (col_q == w_q) & (row_q == h_q);

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_x_d  = addr_x_q;
        addr_y_d  = addr_y_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        csum_d    = csum_q;

        if (xfer) begin
            csum_d = csum_q ^ m_data_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    w_d      = w_m1;
                    h_d      = h_m1;
                    col_d    = 6'd0;
                    row_d    = 5'd0;
                    addr_x_d = x0;
                    addr_y_d = y0;
                    csum_d   = 8'd0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // The presented address is a register so it stays put through stalls and in IDLE.
                if (capture) begin
                    m_data_d  = mem_rd_data;
                    m_valid_d = 1'b1;
                    m_last_d  = last_elem;
                    if (last_elem) begin
                        state_d = DRAIN;
                    end else if (col_q == w_q) begin
                        col_d    = 6'd0;
                        row_d    = row_q + 5'd1;
                        addr_x_d = x0_q;
                        addr_y_d = addr_y_q + 5'd1;
                    end else begin
                        col_d    = col_q + 6'd1;
                        addr_x_d = addr_x_q + 6'd1;
                    end
                end
            end
            DRAIN: begin
                if (xfer) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x0_q      <= 6'd0;
            y0_q      <= 5'd0;
            w_q       <= 6'd0;
            h_q       <= 5'd0;
            col_q     <= 6'd0;
            row_q     <= 5'd0;
            addr_x_q  <= 6'd0;
            addr_y_q  <= 5'd0;
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            csum_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_x_q  <= addr_x_d;
            addr_y_q  <= addr_y_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            csum_q    <= csum_d;
        end
    end

    assign mem_addr_x = addr_x_q;
    assign mem_addr_y = addr_y_q;
    assign mem_wr     = 1'b0;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

`ifdef MEM2D_RD_CSUM_EN
    assign csum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_mem2d_rd_scan.sv
// Scoreboard bench for mem2d_rd_scan: directed scans push expected elements, a monitor pops on each transfer.
// Build with MEM2D_RD_CSUM_EN defined to also check the checksum output.
module tb_mem2d_rd_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] x0 = 6'd0;
    logic [4:0] y0 = 5'd0;
    logic [5:0] w_m1 = 6'd0;
    logic [4:0] h_m1 = 5'd0;
    logic [5:0] mem_addr_x;
    logic [4:0] mem_addr_y;
    logic       mem_wr;
    logic [7:0] mem_rd_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       busy;
    logic       done;
`ifdef MEM2D_RD_CSUM_EN
    logic [7:0] csum;
`endif

    mem2d_rd_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .w_m1        (w_m1),
        .h_m1        (h_m1),
        .mem_addr_x  (mem_addr_x),
        .mem_addr_y  (mem_addr_y),
        .mem_wr      (mem_wr),
        .mem_rd_data (mem_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy),
        .done        (done)
`ifdef MEM2D_RD_CSUM_EN
        ,
        .csum        (csum)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: cell(x,y) = (x*4 + y) & 0xFF
    always_comb mem_rd_data = 8'(({2'b00, mem_addr_x} << 2) + {3'b000, mem_addr_y});

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total = 0;
    int   rdy_mode = 0;
    int   rdy_cnt = 0;
    logic [7:0] csum_model = 8'd0;
    logic [7:0] last_csum = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Ready driver: constant 1, or the repeating pattern 1,0,0
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            m_ready = 1'b1;
        end else begin
            m_ready = (rdy_cnt % 3 == 0);
            rdy_cnt++;
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stalls and the done pulse
    logic       last_prev = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] held = 8'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_prev  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (last_prev) begin
                check("done_after_last", {30'd0, done, busy}, 32'h2);
`ifdef MEM2D_RD_CSUM_EN
                check("csum_at_done", {24'd0, csum}, {24'd0, csum_model});
`endif
                last_csum = csum_model;
            end else if (done) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end
            if (stall_prev && m_valid) begin
                check("stall_hold", {24'd0, m_data}, {24'd0, held});
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_xfer", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("xfer data=0x%02h last=%0d", m_data, m_last);
                    check("xfer_data", {24'd0, m_data}, {24'd0, e.d});
                    check("xfer_last", {31'd0, m_last}, {31'd0, e.l});
                    csum_model = csum_model ^ e.d;
                end
            end
            last_prev  = m_valid && m_ready && m_last;
            stall_prev = m_valid && !m_ready;
            held       = m_data;
        end
    end

    task automatic push_tab(input logic [7:0] tab[], input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d = tab[i];
            e.l = (i == n - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic start_scan(input logic [5:0] x, input logic [4:0] y,
                              input logic [5:0] w, input logic [4:0] h);
        @(negedge clk);
        x0 = x; y0 = y; w_m1 = w; h_m1 = h;
        start = 1'b1;
        csum_model = 8'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < 300) passed++;
        else $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] t034[] = '{8'h2D, 8'h31, 8'h35, 8'h2E, 8'h32, 8'h36};
    logic [7:0] t035[] = '{8'h17, 8'h1B, 8'h1F, 8'h23, 8'hF8, 8'hFC, 8'h00, 8'h04};
    logic [7:0] t038[] = '{8'h2D};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(negedge clk);
        check("rst_addr_x", {26'd0, mem_addr_x}, 32'd0);
        check("rst_addr_y", {27'd0, mem_addr_y}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("mem_wr", {31'd0, mem_wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic region with latency checks
        push_tab(t034, 6);
        start_scan(6'd10, 5'd5, 6'd2, 5'd1);
        check("lat_busy_n1", {31'd0, busy}, 32'd1);
        check("lat_valid_n1", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid_n2", {31'd0, m_valid}, 32'd1);
        wait_idle("scan034");

        // Wrap-around addressing, then IDLE holds the final address
        push_tab(t035, 8);
        start_scan(6'd62, 5'd31, 6'd3, 5'd1);
        wait_idle("scan035");
        check("idle_addr_x", {26'd0, mem_addr_x}, 32'd1);
        check("idle_addr_y", {27'd0, mem_addr_y}, 32'd0);

        // Back-pressure pattern 1,0,0
        rdy_cnt = 0;
        rdy_mode = 1;
        push_tab(t034, 6);
        start_scan(6'd10, 5'd5, 6'd2, 5'd1);
        wait_idle("scan036");
        rdy_mode = 0;

        // Start pulsed mid-scan is ignored
        push_tab(t034, 6);
        start_scan(6'd10, 5'd5, 6'd2, 5'd1);
        repeat (2) @(negedge clk);
        x0 = 6'd0; y0 = 5'd0; w_m1 = 6'd5; h_m1 = 5'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("scan037a");

        // Reset while the third element is presented
        push_tab(t034, 6);
        start_scan(6'd10, 5'd5, 6'd2, 5'd1);
        n = 0;
        while (!(m_valid && m_data == 8'h35) && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("third_elem_seen", {24'd0, m_data}, 32'h35);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_data", {24'd0, m_data}, 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single-element region
        push_tab(t038, 1);
        start_scan(6'd10, 5'd5, 6'd0, 5'd0);
        wait_idle("scan038");
`ifdef MEM2D_RD_CSUM_EN
        check("csum_single_hold", {24'd0, csum}, 32'h2D);
`endif
        check("single_model_xor", {24'd0, last_csum}, 32'h2D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
